punc_mem_arbiter: RTL and testbench
===================================

Name: punc_mem_arbiter

Overview:
Shares the single-port PUnC LC3 memory between two requesters.
- Port 0 is the CPU: the control/datapath fetch, load and store path.
- Port 1 is the debug/loader port: testbench program loading and memory inspection.
- The CPU has fixed priority. A starvation counter guarantees debug progress.
- A lock lets the CPU hold the memory across the two back-to-back accesses of LDI/STI.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 16, memory data width.
- STARVE_LIMIT, 8, consecutive cycles a pending debug request may be denied before it gets priority.
- LOCK_MAX, 4, cycles a lock may be held with the owner's req low before auto-release.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- cpu_req  in  1  CPU access request; held until granted.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_lock  in  1  keep ownership after this access.
- cpu_addr  in  ADDR_W  access address.
- cpu_wdata  in  DATA_W  write data.
- cpu_gnt  out  1  access accepted this cycle.
- cpu_rvalid  out  1  read data valid.
- cpu_rdata  out  DATA_W  read data.
- dbg_req, dbg_we, dbg_lock, dbg_addr, dbg_wdata  in  same widths and meanings as the cpu_* inputs, for the debug port.
- dbg_gnt, dbg_rvalid, dbg_rdata  out  same widths and meanings as the cpu_* outputs, for the debug port.
- mem_addr  out  ADDR_W  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous memory read data, valid one cycle after the address.

Behaviour:
- State machine, 2-bit owner state:
  - IDLE: no lock.
  - LOCK_CPU: only the CPU may be granted.
  - LOCK_DBG: only the debug port may be granted.
- Grant is combinational from the registered state and the current requests. At most one gnt per cycle.
- Grant rules:
  - IDLE: if STARVE_LIMIT is reached and dbg_req, grant dbg. Otherwise grant cpu if cpu_req, else grant dbg if dbg_req.
  - LOCK_x: grant x if x_req; the other port is never granted.
- Memory mux:
  - In a grant cycle, mem_addr, mem_we and mem_wdata come from the granted port.
  - With no grant, mem_we = 0 and mem_addr/mem_wdata hold the CPU's values (don't-care, but no write).
- Read return:
  - For a granted read (we = 0), x_rvalid pulses exactly one cycle later and x_rdata = mem_rdata in that cycle.
  - x_rdata is registered and holds its last value otherwise.
  - Writes produce no rvalid.
- Back-to-back grants every cycle are legal (throughput 1 access per cycle).
- Lock transitions:
  - IDLE -> LOCK_x when x is granted with x_lock = 1.
  - LOCK_x -> IDLE when x is granted with x_lock = 0.
  - LOCK_x -> LOCK_x when x is granted with x_lock = 1.
- Lock timeout:
  - A counter increments each cycle in LOCK_x while x_req = 0, and clears on any grant.
  - When the counter reaches LOCK_MAX, the state returns to IDLE at the next edge.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle dbg_req = 1 and dbg_gnt = 0.
  - Clears on dbg_gnt, or when dbg_req = 0.
  - Has no effect while in LOCK_CPU.
  - Once the lock releases, the saturated count gives dbg first grant.
- Simultaneous requests in IDLE with count below the limit: CPU wins.
- Reset (asynchronous, any cycle, including mid-lock or with a read in flight):
  - State = IDLE; both counters = 0.
  - x_rvalid = 0 and x_rdata = 0 immediately.
  - The pending read is discarded: no rvalid after reset deasserts.
  - gnt outputs and mem_we are forced to 0 while rst = 1.
- Requesters must hold req, we, addr, wdata and lock stable until gnt. Changes before grant are simply re-sampled; there is no error flag.

Decomposition:
- Shared package defines/localparams:
  - owner state encodings: IDLE = 2'd0, LOCK_CPU = 2'd1, LOCK_DBG = 2'd2;
  - port indices: PORT_CPU = 0, PORT_DBG = 1;
  - default widths.
- One natural sub-module: punc_sat_counter. It is a saturating up-counter with clear, parameterized by limit, and is instantiated twice, for starvation and lock timeout.
- The top contains the FSM, grant logic, mux and read-return pipeline.

Test Plan:
- Reset mid-read:
  - Stimulus: cpu read addr 0x3000 granted, rst asserted in the following cycle before its edge.
  - Required response: cpu_rvalid never pulses, cpu_rdata = 0x0000, state IDLE.
- Basic read/write:
  - Stimulus: dbg write 0x3000 <- 0xBEEF, then cpu read 0x3000.
  - Required response: cpu_gnt in the cycle after dbg_gnt; cpu_rvalid = 1 with cpu_rdata = 0xBEEF one cycle after cpu_gnt.
- Priority:
  - Stimulus: cpu_req and dbg_req both high in the same IDLE cycle.
  - Required response: cpu_gnt = 1, dbg_gnt = 0, mem_addr = cpu_addr.
- Starvation:
  - Stimulus: cpu_req held high continuously, dbg_req high.
  - Required response: dbg_gnt asserts on the 9th cycle (STARVE_LIMIT = 8), then cpu regains grant on the next cycle.
- Lock (LDI pattern):
  - Stimulus: cpu read 0x3001 with lock = 1 while dbg_req is held; 2 idle cycles; cpu read 0x4000 with lock = 0.
  - Required response: dbg never granted until after the second cpu grant; dbg_gnt on the following cycle.
- Lock timeout:
  - Stimulus: cpu granted with lock = 1, then cpu_req = 0 for 4 cycles while dbg_req = 1.
  - Required response: state returns to IDLE after LOCK_MAX; dbg_gnt asserts in the next cycle.

Source files
------------

// File: rtl/punc_mem_arbiter_pkg.sv
// Shared definitions for the PUnC memory arbiter: owner encodings, port indices
// and default widths.
package punc_mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF       = 16;
    localparam int unsigned DATA_W_DEF       = 16;
    localparam int unsigned STARVE_LIMIT_DEF = 8;
    localparam int unsigned LOCK_MAX_DEF     = 4;

    localparam int unsigned PORT_CPU  = 0;
    localparam int unsigned PORT_DBG  = 1;
    localparam int unsigned NUM_PORTS = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCK_CPU = 2'd1,
        LOCK_DBG = 2'd2
    } owner_e;

    // Bits needed to hold values 0..limit inclusive.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/punc_mem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the limit is held.
module punc_sat_counter #(
    parameter int unsigned LIMIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);
    import punc_mem_arbiter_pkg::*;

    localparam int unsigned        CNT_W   = cnt_width(LIMIT);
    localparam logic [CNT_W-1:0]   LIMIT_V = CNT_W'(LIMIT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != LIMIT_V)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == LIMIT_V);

endmodule

// File: rtl/punc_mem_arbiter.sv
// Single-port LC3 memory arbiter: CPU has fixed priority, debug port is protected
// from starvation, and either port may lock the memory across back-to-back accesses.
module punc_mem_arbiter
    import punc_mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned LOCK_MAX     = LOCK_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_lock,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    owner_e                 state_q;
    owner_e                 state_d;
    logic [NUM_PORTS-1:0]   gnt_c;
    logic                   locked;
    logic                   owner_req;
    logic                   starve_hit;
    logic                   lock_expired;

    logic                   cpu_rd_q;
    logic                   cpu_rd_d;
    logic                   dbg_rd_q;
    logic                   dbg_rd_d;
    logic [DATA_W-1:0]      cpu_hold_q;
    logic [DATA_W-1:0]      cpu_hold_d;
    logic [DATA_W-1:0]      dbg_hold_q;
    logic [DATA_W-1:0]      dbg_hold_d;

    assign locked    = (state_q != IDLE);
    assign owner_req = (state_q == LOCK_CPU) ? cpu_req : dbg_req;

    // Counts denied cycles of a pending debug request; saturates to force a debug grant.
    punc_sat_counter #(
        .LIMIT    (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (dbg_req & ~gnt_c[PORT_DBG]),
        .clr      (gnt_c[PORT_DBG] | ~dbg_req),
        .at_limit (starve_hit)
    );

    // Counts idle cycles of a lock owner so an abandoned lock cannot wedge the memory.
    punc_sat_counter #(
        .LIMIT    (LOCK_MAX)
    ) u_lock_cnt (
        .clk      (clk),
        .rst      (rst),
        .inc      (locked & ~owner_req),
        .clr      ((|gnt_c) | ~locked),
        .at_limit (lock_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (gnt_c[PORT_CPU]) begin
            state_d = cpu_lock ? LOCK_CPU : IDLE;
        end else if (gnt_c[PORT_DBG]) begin
            state_d = dbg_lock ? LOCK_DBG : IDLE;
        end else if (locked && lock_expired) begin
            state_d = IDLE;
        end
    end

    // Grant selection and memory mux; nothing is granted or written while in reset.
    always_comb begin
        gnt_c = '0;
        case (state_q)
            IDLE: begin
                if (starve_hit && dbg_req) begin
                    gnt_c[PORT_DBG] = 1'b1;
                end else if (cpu_req) begin
                    gnt_c[PORT_CPU] = 1'b1;
                end else if (dbg_req) begin
                    gnt_c[PORT_DBG] = 1'b1;
                end
            end
            LOCK_CPU: gnt_c[PORT_CPU] = cpu_req;
            LOCK_DBG: gnt_c[PORT_DBG] = dbg_req;
            default:  gnt_c = '0;
        endcase
        if (rst) begin
            gnt_c = '0;
        end

        if (gnt_c[PORT_DBG]) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = dbg_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = gnt_c[PORT_CPU] & cpu_we;
        end
    end

    assign cpu_gnt = gnt_c[PORT_CPU];
    assign dbg_gnt = gnt_c[PORT_DBG];

    // Read return: memory answers one cycle after the grant; last data is held.
    always_comb begin
        cpu_rd_d   = gnt_c[PORT_CPU] & ~cpu_we;
        dbg_rd_d   = gnt_c[PORT_DBG] & ~dbg_we;
        cpu_hold_d = cpu_rd_q ? mem_rdata : cpu_hold_q;
        dbg_hold_d = dbg_rd_q ? mem_rdata : dbg_hold_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rd_q   <= 1'b0;
            dbg_rd_q   <= 1'b0;
            cpu_hold_q <= '0;
            dbg_hold_q <= '0;
        end else begin
            cpu_rd_q   <= cpu_rd_d;
            dbg_rd_q   <= dbg_rd_d;
            cpu_hold_q <= cpu_hold_d;
            dbg_hold_q <= dbg_hold_d;
        end
    end

    assign cpu_rvalid = cpu_rd_q;
    assign dbg_rvalid = dbg_rd_q;
    assign cpu_rdata  = cpu_rd_q ? mem_rdata : cpu_hold_q;
    assign dbg_rdata  = dbg_rd_q ? mem_rdata : dbg_hold_q;

endmodule

// File: tb/tb_punc_mem_arbiter.sv
// Scoreboard bench for punc_mem_arbiter: directed scenarios followed by random
// traffic, checked against a cycle-level reference of the arbitration rules.
module tb_punc_mem_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int SL = 8;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we, cpu_lock;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          dbg_req, dbg_we, dbg_lock;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [DW-1:0] dbg_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    punc_mem_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .LOCK_MAX(LM)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_lock(cpu_lock),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock),
        .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Synchronous single-port memory driven by the arbiter.
    logic [DW-1:0] env_mem [0:65535];
    initial for (int i = 0; i < 65536; i++) env_mem[i] <= init_val(AW'(i));
    always @(posedge clk) begin
        if (mem_we) env_mem[mem_addr] <= mem_wdata;
        mem_rdata <= env_mem[mem_addr];
    end

    // Reference model state.
    logic [DW-1:0] ref_mem [0:65535];
    int            m_owner;
    int            m_starve;
    int            m_idle;
    logic [DW-1:0] m_last [2];
    int            cyc;

    typedef struct {
        int            cyc;
        logic          cg;
        logic          dg;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
    } exp_t;
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;
    exp_t exp_q[$];
    rd_t  rdq0[$];
    rd_t  rdq1[$];

    logic          p_req  [2];
    logic          p_we   [2];
    logic          p_lock [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_wd   [2];

    int n_vec;
    int n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic set_req(input int p, input logic we, input logic lk,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_req[p] = 1'b1; p_we[p] = we; p_lock[p] = lk; p_addr[p] = a; p_wd[p] = d;
    endtask

    task automatic model_reset();
        m_owner = -1; m_starve = 0; m_idle = 0;
        m_last[0] = '0; m_last[1] = '0;
        rdq0.delete(); rdq1.delete();
    endtask

    // Drive one cycle of inputs and predict the arbiter's response to them.
    task automatic step(input logic r);
        int   g;
        exp_t e;
        rd_t  rd;
        @(posedge clk);
        #1;
        cyc++;
        rst = r;
        cpu_req = p_req[0]; cpu_we = p_we[0]; cpu_lock = p_lock[0];
        cpu_addr = p_addr[0]; cpu_wdata = p_wd[0];
        dbg_req = p_req[1]; dbg_we = p_we[1]; dbg_lock = p_lock[1];
        dbg_addr = p_addr[1]; dbg_wdata = p_wd[1];

        g = -1;
        if (!r) begin
            if (m_owner < 0) begin
                if (m_starve >= SL && p_req[1]) g = 1;
                else if (p_req[0])              g = 0;
                else if (p_req[1])              g = 1;
            end else if (p_req[m_owner]) begin
                g = m_owner;
            end
        end

        e.cyc  = cyc;
        e.cg   = (g == 0);
        e.dg   = (g == 1);
        e.we   = (g >= 0) ? p_we[g] : 1'b0;
        e.addr = (g == 1) ? p_addr[1] : p_addr[0];
        e.wd   = (g == 1) ? p_wd[1]   : p_wd[0];
        exp_q.push_back(e);

        if (r) begin
            model_reset();
        end else begin
            if (g >= 0) begin
                if (p_we[g]) begin
                    ref_mem[p_addr[g]] = p_wd[g];
                end else begin
                    rd.due  = cyc + 1;
                    rd.data = ref_mem[p_addr[g]];
                    if (g == 0) rdq0.push_back(rd); else rdq1.push_back(rd);
                end
            end
            if (g == 1 || !p_req[1]) m_starve = 0;
            else if (m_starve < SL)  m_starve++;
            if (g >= 0) begin
                m_owner = p_lock[g] ? g : -1;
                m_idle  = 0;
                p_req[g] = 1'b0;
            end else if (m_owner >= 0) begin
                if (m_idle >= LM) begin
                    m_owner = -1;
                    m_idle  = 0;
                end else if (!p_req[m_owner]) begin
                    m_idle++;
                end
            end
        end
    endtask

    // Monitor: compares every cycle's outputs against the predicted record.
    initial begin
        exp_t          e;
        rd_t           t;
        logic          ev;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) continue;
            e = exp_q.pop_front();
            chk("cpu_gnt",   32'(cpu_gnt),   32'(e.cg));
            chk("dbg_gnt",   32'(dbg_gnt),   32'(e.dg));
            chk("mem_we",    32'(mem_we),    32'(e.we));
            chk("mem_addr",  32'(mem_addr),  32'(e.addr));
            chk("mem_wdata", 32'(mem_wdata), 32'(e.wd));
            ev = 1'b0; ed = '0;
            if (rdq0.size() > 0 && rdq0[0].due == e.cyc) begin
                t = rdq0.pop_front(); ev = 1'b1; ed = t.data; m_last[0] = ed;
            end
            chk("cpu_rvalid", 32'(cpu_rvalid), 32'(ev));
            chk("cpu_rdata",  32'(cpu_rdata),  32'(m_last[0]));
            ev = 1'b0;
            if (rdq1.size() > 0 && rdq1[0].due == e.cyc) begin
                t = rdq1.pop_front(); ev = 1'b1; ed = t.data; m_last[1] = ed;
            end
            chk("dbg_rvalid", 32'(dbg_rvalid), 32'(ev));
            chk("dbg_rdata",  32'(dbg_rdata),  32'(m_last[1]));
        end
    end

    initial begin
        n_vec = 0; n_err = 0; cyc = 0;
        rst = 1'b1;
        for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 16'h0000, 16'h0000);
        p_req[0] = 1'b0; p_req[1] = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_lock = 0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(AW'(i));
        model_reset();

        repeat (3) step(1'b1);
        step(1'b0);

        // Basic: debug write then CPU read of the same word.
        set_req(1, 1'b1, 1'b0, 16'h3000, 16'hBEEF);
        step(1'b0);
        set_req(0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        step(1'b0);
        step(1'b0);
        @(negedge clk); #1;
        chk("basic_rdata", 32'(cpu_rdata), 32'h0000BEEF);

        // Priority: simultaneous requests in IDLE.
        set_req(0, 1'b0, 1'b0, 16'h3002, 16'h0000);
        set_req(1, 1'b0, 1'b0, 16'h3003, 16'h0000);
        step(1'b0);
        @(negedge clk); #1;
        chk("prio_cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("prio_mem_addr", 32'(mem_addr), 32'h3002);
        step(1'b0);

        // Starvation: CPU requests every cycle, debug waits for the limit.
        set_req(1, 1'b0, 1'b0, 16'h3004, 16'h0000);
        for (int i = 1; i <= 10; i++) begin
            if (!p_req[0]) set_req(0, 1'b0, 1'b0, AW'(16'h3008 + i), 16'h0000);
            step(1'b0);
            if (i == 9) begin
                @(negedge clk); #1;
                chk("starve_dbg_gnt9", 32'(dbg_gnt), 32'd1);
            end
            if (i == 10) begin
                @(negedge clk); #1;
                chk("starve_cpu_back", 32'(cpu_gnt), 32'd1);
            end
        end
        p_req[0] = 1'b0;
        step(1'b0);

        // LDI pattern: locked read, idle gap, unlocking read, then debug.
        set_req(0, 1'b0, 1'b1, 16'h3001, 16'h0000);
        set_req(1, 1'b0, 1'b0, 16'h3005, 16'h0000);
        step(1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0);
            @(negedge clk); #1;
            chk("ldi_dbg_blocked", 32'(dbg_gnt), 32'd0);
        end
        set_req(0, 1'b0, 1'b0, 16'h4000, 16'h0000);
        step(1'b0);
        step(1'b0);
        @(negedge clk); #1;
        chk("ldi_dbg_after", 32'(dbg_gnt), 32'd1);

        // Lock timeout: owner abandons the lock while debug waits.
        set_req(0, 1'b0, 1'b1, 16'h3006, 16'h0000);
        step(1'b0);
        set_req(1, 1'b0, 1'b0, 16'h3007, 16'h0000);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0);
            @(negedge clk); #1;
            chk("timeout_dbg_gnt", 32'(dbg_gnt), (i == 6) ? 32'd1 : 32'd0);
        end

        // Reset while a CPU read is in flight.
        set_req(0, 1'b0, 1'b0, 16'h3000, 16'h0000);
        step(1'b0);
        @(negedge clk); #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'd0);
        chk("rst_cpu_rdata",  32'(cpu_rdata),  32'h0000);
        chk("rst_cpu_gnt",    32'(cpu_gnt),    32'd0);
        step(1'b1);
        step(1'b0);
        step(1'b0);

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            if (!p_req[0] && $urandom_range(99) < 70)
                set_req(0, 1'($urandom_range(1)), 1'($urandom_range(7) == 0),
                        AW'(16'h3000 + $urandom_range(15)), DW'($urandom));
            if (!p_req[1] && $urandom_range(99) < 40)
                set_req(1, 1'($urandom_range(1)), 1'($urandom_range(7) == 0),
                        AW'(16'h3000 + $urandom_range(15)), DW'($urandom));
            step(1'($urandom_range(599) == 0));
        end

        p_req[0] = 1'b0; p_req[1] = 1'b0;
        repeat (8) step(1'b0);
        @(negedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
